// File: rtl/common.sv
// Shared machine-word and data-bus types used across the pipeline.
package common;

  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    MsizeB = 2'd0,
    MsizeH = 2'd1,
    MsizeW = 2'd2,
    MsizeD = 2'd3
  } msize_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    msize_t     size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Inter-stage payload types for the execute -> memory -> writeback path.
package pipes;
  import common::*;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   mem_unsigned;
    logic   nop_signal;
  } control_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    creg_addr_t wa;
    word_t      result_alu;
    word_t      rs2;
  } execute_data_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    creg_addr_t wa;
    word_t      result_alu;
    word_t      wd;
    logic       addr_31;
  } memory_data_t;

  // Bubble: everything zero except nop_signal, so writeback ignores it.
  function automatic memory_data_t bubble_md();
    memory_data_t m;
    m = '0;
    m.ctl.nop_signal = 1'b1;
    return m;
  endfunction

  function automatic memory_data_t to_mem(execute_data_t e, word_t wd);
    memory_data_t m;
    m.pc         = e.pc;
    m.ctl        = e.ctl;
    m.wa         = e.wa;
    m.result_alu = e.result_alu;
    m.wd         = wd;
    m.addr_31    = e.result_alu[31];
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the data bus: store shift/strobe and load shift/extend.
module mem_align
  import common::*;
(
  input  logic [2:0] offset,
  input  msize_t     size,
  input  logic       mem_unsigned,
  input  word_t      store_src,
  input  word_t      load_src,
  output word_t      store_data,
  output logic [7:0] store_strobe,
  output word_t      load_data
);

  logic [5:0] shamt;
  logic [7:0] base;
  word_t      raw;

  assign shamt = {offset, 3'b000};

  always_comb begin
    base      = 8'h00;
    load_data = '0;

    store_data = store_src << shamt;
    unique case (size)
      MsizeB: base = 8'h01;
      MsizeH: base = 8'h03;
      MsizeW: base = 8'h0f;
      MsizeD: base = 8'hff;
    endcase
    // Lanes past byte 7 fall off: misaligned accesses are truncated, not trapped.
    store_strobe = base << offset;

    raw = load_src >> shamt;
    unique case (size)
      MsizeB: load_data = mem_unsigned ? {56'b0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
      MsizeH: load_data = mem_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      MsizeW: load_data = mem_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      MsizeD: load_data = raw;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues one data-bus access per load/store and stalls upstream until data_ok.
module memory_access
  import common::*;
  import pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          in_valid,
  output logic          in_ready,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state_q;
  execute_data_t req_q;
  memory_data_t  data_m_q;

  word_t      store_data;
  logic [7:0] store_strobe;
  word_t      load_data;

  mem_align u_align (
    .offset       (req_q.result_alu[2:0]),
    .size         (req_q.ctl.msize),
    .mem_unsigned (req_q.ctl.mem_unsigned),
    .store_src    (req_q.rs2),
    .load_src     (dresp.data),
    .store_data   (store_data),
    .store_strobe (store_strobe),
    .load_data    (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      req_q    <= '0;
      data_m_q <= bubble_md();
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && !dataE.ctl.nop_signal) begin
            if (dataE.ctl.memread || dataE.ctl.memwrite) begin
              req_q    <= dataE;
              data_m_q <= bubble_md();
              state_q  <= StWait;
            end else begin
              data_m_q <= to_mem(dataE, '0);
            end
          end else begin
            data_m_q <= bubble_md();
          end
        end
        StWait: begin
          // New instructions presented here are held upstream by stallM.
          if (dresp.data_ok) begin
            data_m_q <= to_mem(req_q, req_q.ctl.memread ? load_data : '0);
            state_q  <= StIdle;
          end else begin
            data_m_q <= bubble_md();
          end
        end
      endcase
    end
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = (state_q == StWait);
    dreq.addr   = req_q.result_alu;
    dreq.size   = req_q.ctl.msize;
    dreq.strobe = req_q.ctl.memwrite ? store_strobe : 8'h00;
    dreq.data   = store_data;
  end

  assign in_ready = (state_q == StIdle);
  assign stallM   = (state_q == StWait);
  assign dataM    = data_m_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a queue scoreboard on dataM.
module tb_memory_access;
  import common::*;
  import pipes::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          in_valid;
  logic          in_ready;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stallM;

  int total = 0;
  int bad   = 0;
  memory_data_t exp_q[$];

  memory_access dut (
    .clk      (clk),
    .reset    (reset),
    .dataE    (dataE),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dreq     (dreq),
    .dresp    (dresp),
    .dataM    (dataM),
    .stallM   (stallM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic execute_data_t mk(input word_t pc, input logic rw, input logic rd,
                                       input logic wr, input msize_t sz, input logic uns,
                                       input logic [4:0] wa, input word_t alu, input word_t rs2);
    execute_data_t d;
    d = '0;
    d.pc = pc;
    d.ctl.regwrite = rw;
    d.ctl.memread = rd;
    d.ctl.memwrite = wr;
    d.ctl.msize = sz;
    d.ctl.mem_unsigned = uns;
    d.wa = wa;
    d.result_alu = alu;
    d.rs2 = rs2;
    return d;
  endfunction

  function automatic memory_data_t exp_md(input execute_data_t d, input word_t wd);
    memory_data_t m;
    m.pc = d.pc;
    m.ctl = d.ctl;
    m.wa = d.wa;
    m.result_alu = d.result_alu;
    m.wd = wd;
    m.addr_31 = d.result_alu[31];
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every non-bubble dataM must match the head of the queue.
  always @(negedge clk) begin : monitor
    memory_data_t e;
    if (!reset && dataM.ctl.nop_signal !== 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_dataM pc=%h wd=%h", dataM.pc, dataM.wd);
      end else begin
        e = exp_q.pop_front();
        if (dataM !== e) begin
          bad++;
          $display("FAIL dataM pc=%h got wd=%h alu=%h wa=%0d a31=%b ctl=%b want pc=%h wd=%h alu=%h wa=%0d a31=%b ctl=%b",
                   dataM.pc, dataM.wd, dataM.result_alu, dataM.wa, dataM.addr_31, dataM.ctl,
                   e.pc, e.wd, e.result_alu, e.wa, e.addr_31, e.ctl);
        end
      end
    end
  end

  task automatic send(input execute_data_t d);
    dataE = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dataE = '0;
  endtask

  task automatic mem_op(input string name, input execute_data_t d, input int waits,
                        input word_t rdata, input word_t exp_wd, input logic [7:0] exp_strobe,
                        input word_t exp_data);
    int stalls;
    stalls = 0;
    exp_q.push_back(exp_md(d, exp_wd));
    send(d);
    check({name, "_valid"}, 64'(dreq.valid), 64'd1);
    check({name, "_addr"}, dreq.addr, d.result_alu);
    check({name, "_size"}, 64'(dreq.size), 64'(d.ctl.msize));
    check({name, "_strobe"}, 64'(dreq.strobe), 64'(exp_strobe));
    if (exp_strobe != 8'h00) check({name, "_wdata"}, dreq.data, exp_data);
    for (int i = 0; i <= waits; i++) begin
      if (stallM) stalls++;
      if (i == waits) begin
        dresp.data_ok = 1'b1;
        dresp.data = rdata;
      end
      @(posedge clk);
      #1;
      dresp.data_ok = 1'b0;
    end
    check({name, "_stalls"}, 64'(stalls), 64'(waits + 1));
    check({name, "_done"}, 64'({stallM, in_ready, dataM.ctl.nop_signal}), 64'(3'b010));
  endtask

  initial begin
    memory_data_t b;
    execute_data_t d;
    b = '0;
    b.ctl.nop_signal = 1'b1;
    reset = 1'b0;
    in_valid = 1'b0;
    dataE = '0;
    dresp = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_valid", 64'(dreq.valid), 64'd0);
    check("rst_stall", 64'(stallM), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    total++;
    if (dataM !== b) begin
      bad++;
      $display("FAIL rst_dataM got=%h want=%h", dataM, b);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // ALU op: one-cycle latency, no bus request.
    d = mk(64'h100, 1'b1, 1'b0, 1'b0, MsizeB, 1'b0, 5'd5, 64'h1234, 64'h0);
    exp_q.push_back(exp_md(d, 64'h0));
    send(d);
    check("alu_valid", 64'(dreq.valid), 64'd0);
    check("alu_stall", 64'(stallM), 64'd0);
    check("alu_out", dataM.result_alu, 64'h1234);

    mem_op("lb", mk(64'h104, 1'b1, 1'b1, 1'b0, MsizeB, 1'b0, 5'd6, 64'h8000_0003, 64'h0),
           3, 64'h0000_0000_FF00_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0);
    mem_op("sh", mk(64'h108, 1'b0, 1'b0, 1'b1, MsizeH, 1'b0, 5'd0, 64'h8000_0006, 64'hABCD),
           1, 64'h0, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000);
    mem_op("lwu", mk(64'h10C, 1'b1, 1'b1, 1'b0, MsizeW, 1'b1, 5'd7, 64'h1000_0004, 64'h0),
           0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 8'h00, 64'h0);
    mem_op("lh", mk(64'h110, 1'b1, 1'b1, 1'b0, MsizeH, 1'b0, 5'd8, 64'h2002, 64'h0),
           2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0);
    mem_op("sw_mis", mk(64'h114, 1'b0, 1'b0, 1'b1, MsizeW, 1'b0, 5'd0, 64'h6, 64'h1122_3344),
           0, 64'h0, 64'h0, 8'hC0, 64'h3344_0000_0000_0000);
    mem_op("ld", mk(64'h118, 1'b1, 1'b1, 1'b0, MsizeD, 1'b0, 5'd9, 64'h8, 64'h0),
           1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);
    mem_op("sb", mk(64'h11C, 1'b0, 1'b0, 1'b1, MsizeB, 1'b0, 5'd0, 64'h1, 64'hFF12),
           0, 64'h0, 64'h0, 8'h02, 64'h0000_0000_00FF_1200);
    mem_op("lbu", mk(64'h120, 1'b1, 1'b1, 1'b0, MsizeB, 1'b1, 5'd10, 64'h7, 64'h0),
           0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080, 8'h00, 64'h0);

    // nop_signal suppresses even a load.
    d = mk(64'h124, 1'b1, 1'b1, 1'b0, MsizeD, 1'b0, 5'd11, 64'h40, 64'h0);
    d.ctl.nop_signal = 1'b1;
    send(d);
    check("nop_valid", 64'(dreq.valid), 64'd0);
    check("nop_bubble", 64'(dataM.ctl.nop_signal), 64'd1);

    // in_valid low: bubble regardless of dataE.
    dataE = mk(64'h128, 1'b1, 1'b0, 1'b0, MsizeB, 1'b0, 5'd12, 64'h55, 64'h0);
    @(posedge clk);
    #1;
    check("idle_bubble", 64'(dataM.ctl.nop_signal), 64'd1);

    // Next instruction held through WAIT is accepted exactly once afterwards.
    d = mk(64'h130, 1'b1, 1'b1, 1'b0, MsizeD, 1'b0, 5'd13, 64'h100, 64'h0);
    exp_q.push_back(exp_md(d, 64'hDEAD_BEEF_0000_0001));
    dataE = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    d = mk(64'h134, 1'b1, 1'b0, 1'b0, MsizeB, 1'b0, 5'd14, 64'h9999, 64'h0);
    exp_q.push_back(exp_md(d, 64'h0));
    dataE = d;
    @(posedge clk);
    #1;
    check("hold_ready", 64'(in_ready), 64'd0);
    dresp.data_ok = 1'b1;
    dresp.data = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk);
    #1;
    dresp.data_ok = 1'b0;
    check("hold_ret_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dataE = '0;
    check("hold_accept", dataM.result_alu, 64'h9999);

    // Reset in WAIT abandons the access; late data_ok is ignored.
    send(mk(64'h140, 1'b1, 1'b1, 1'b0, MsizeD, 1'b0, 5'd15, 64'h200, 64'h0));
    check("rw_valid_pre", 64'(dreq.valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rw_valid_async", 64'(dreq.valid), 64'd0);
    check("rw_stall_async", 64'(stallM), 64'd0);
    check("rw_ready_async", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data = 64'h1111_2222_3333_4444;
    @(posedge clk);
    #1;
    dresp.data_ok = 1'b0;
    check("rw_late_valid", 64'(dreq.valid), 64'd0);
    check("rw_late_stall", 64'(stallM), 64'd0);
    check("rw_late_bubble", 64'(dataM.ctl.nop_signal), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
